// File: rtl/iomem_initiator.sv
// iomem_initiator: command-FIFO fed initiator for the PicoSoC iomem bus.
// Each queued command becomes one bus transaction; an unanswered request times out into an error response.
module iomem_initiator #(
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_write,
    output logic        rsp_error,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    output logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_rdata,
    output logic        busy
);
    localparam int AW = $clog2(CMD_DEPTH);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } entry_t;

    entry_t        fifo_q [CMD_DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop, full, empty;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ivalid_q, ivalid_d;
    logic [31:0]   iaddr_q, iaddr_d, iwdata_q, iwdata_d;
    logic [3:0]    iwstrb_q, iwstrb_d;
    logic          rvalid_q, rvalid_d, rwrite_q, rwrite_d, rerror_q, rerror_d;
    logic [31:0]   rrdata_q, rrdata_d;

    assign full      = (count_q == (AW+1)'(CMD_DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = resetn & ~full;
    assign push      = cmd_valid & cmd_ready;
    assign head      = fifo_q[rd_ptr_q];

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= {cmd_addr, cmd_wdata, cmd_wstrb};
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + (AW+1)'(1);
        else if (!push && pop) count_d = count_q - (AW+1)'(1);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ivalid_d = ivalid_q;
        iaddr_d  = iaddr_q;
        iwdata_d = iwdata_q;
        iwstrb_d = iwstrb_q;
        rvalid_d = rvalid_q;
        rwrite_d = rwrite_q;
        rerror_d = rerror_q;
        rrdata_d = rrdata_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    iaddr_d  = head.addr;
                    iwdata_d = head.wdata;
                    iwstrb_d = head.wstrb;
                    ivalid_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (iomem_ready) begin
                    ivalid_d = 1'b0;
                    rvalid_d = 1'b1;
                    rwrite_d = (iwstrb_q != '0);
                    rerror_d = 1'b0;
                    rrdata_d = (iwstrb_q == '0) ? iomem_rdata : '0;
                    state_d  = RSP;
                end else begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
                    // Compared before the increment so valid stays up exactly TIMEOUT_CYCLES cycles.
                    if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                        ivalid_d = 1'b0;
                        rvalid_d = 1'b1;
                        rwrite_d = (iwstrb_q != '0);
                        rerror_d = 1'b1;
                        rrdata_d = '0;
                        state_d  = RSP;
                    end
                end
            end
            RSP: begin
                if (rvalid_q && rsp_ready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            ivalid_q <= 1'b0;
            iaddr_q  <= '0;
            iwdata_q <= '0;
            iwstrb_q <= '0;
            rvalid_q <= 1'b0;
            rwrite_q <= 1'b0;
            rerror_q <= 1'b0;
            rrdata_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ivalid_q <= ivalid_d;
            iaddr_q  <= iaddr_d;
            iwdata_q <= iwdata_d;
            iwstrb_q <= iwstrb_d;
            rvalid_q <= rvalid_d;
            rwrite_q <= rwrite_d;
            rerror_q <= rerror_d;
            rrdata_q <= rrdata_d;
        end
    end

    assign iomem_valid = ivalid_q;
    assign iomem_addr  = iaddr_q;
    assign iomem_wdata = iwdata_q;
    assign iomem_wstrb = iwstrb_q;
    assign rsp_valid   = rvalid_q;
    assign rsp_rdata   = rrdata_q;
    assign rsp_write   = rwrite_q;
    assign rsp_error   = rerror_q;
    assign busy        = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_iomem_initiator.sv
// Bench for iomem_initiator: directed scenarios then random traffic, checked against a queue-based
// model of command order, responder latency and the timeout rule.
module tb_iomem_initiator;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_write;
    logic        rsp_error;
    logic        iomem_valid;
    logic        iomem_ready = 1'b0;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_rdata = '0;
    logic        busy;

    always #5 clk = ~clk;

    iomem_initiator #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_write(rsp_write), .rsp_error(rsp_error),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_wstrb(iomem_wstrb),
        .iomem_rdata(iomem_rdata), .busy(busy)
    );

    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } cmd_t;
    typedef struct { logic [31:0] rdata; logic write; logic error; } rsp_t;

    cmd_t feed_q[$];
    cmd_t pend[$];
    rsp_t expq[$];
    cmd_t cur;
    int total = 0, bad = 0, accepted = 0, rsp_cnt = 0;
    int cmd_pct = 100, rsp_pct = 100, spur_pct = 0, force_d = 0;
    logic [31:0] force_rd = '0;
    logic [31:0] rd_cur = '0;
    bit use_rd = 1'b0;
    int d_cur = 0, c_valid = 0;
    bit prev_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        if (feed_q.size() != 0 && $urandom_range(99) < cmd_pct) begin
            cmd_valid = 1'b1;
            cmd_addr  = feed_q[0].addr;
            cmd_wdata = feed_q[0].wdata;
            cmd_wstrb = feed_q[0].wstrb;
        end else begin
            cmd_valid = 1'b0;
        end
        rsp_ready = ($urandom_range(99) < rsp_pct);
    endtask

    // One clock: note handshakes due at the coming edge, then act as responder/monitor after it.
    task automatic cyc();
        rsp_t e;
        if (cmd_valid && cmd_ready) begin
            pend.push_back(feed_q.pop_front());
            accepted++;
        end
        if (rsp_valid && rsp_ready) begin
            rsp_cnt++;
            chk("rsp_expected", rsp_valid, expq.size() != 0);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("rsp_error", rsp_error, e.error);
                chk("rsp_rdata", rsp_rdata, e.rdata);
                if (!e.error) chk("rsp_write", rsp_write, e.write);
            end
        end
        @(posedge clk); #1;
        iomem_ready = 1'b0;
        if (iomem_valid) begin
            if (!prev_valid) begin
                chk("issue_expected", iomem_valid, pend.size() != 0);
                if (pend.size() != 0) cur = pend.pop_front();
                else cur = '{32'h0, 32'h0, 4'h0};
                d_cur   = (force_d != 0) ? force_d : int'($urandom_range(1, T + 3));
                rd_cur  = use_rd ? force_rd : $urandom();
                c_valid = 1;
                e.error = (d_cur > T);
                e.write = (cur.wstrb != 4'h0);
                e.rdata = (e.error || e.write) ? 32'h0 : rd_cur;
                expq.push_back(e);
            end else begin
                c_valid++;
            end
            chk("iomem_addr", iomem_addr, cur.addr);
            chk("iomem_wdata", iomem_wdata, cur.wdata);
            chk("iomem_wstrb", {28'h0, iomem_wstrb}, {28'h0, cur.wstrb});
            if (c_valid == d_cur) begin
                iomem_ready = 1'b1;
                iomem_rdata = rd_cur;
            end
        end else begin
            if (prev_valid) chk("valid_cycles", c_valid, (d_cur < T) ? d_cur : T);
            if ($urandom_range(99) < spur_pct) begin
                iomem_ready = 1'b1;
                iomem_rdata = $urandom();
            end
        end
        prev_valid = iomem_valid;
        drive();
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((feed_q.size() != 0 || pend.size() != 0 || expq.size() != 0 ||
                iomem_valid || rsp_valid) && n < budget) begin
            cyc();
            n++;
        end
        chk({tag, "_drain_in_budget"}, n < budget, 1);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int base, n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_iomem_valid", iomem_valid, 0);
        chk("rst_iomem_addr", iomem_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        resetn = 1'b1;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // 1: write, ready 2 cycles after valid
        feed_q.push_back('{32'h0300_0500, 32'h0000_0080, 4'hF});
        force_d = 3;
        drive();
        cyc();
        chk("t1_lat_n", iomem_valid, 0);
        cyc();
        chk("t1_lat_n1", iomem_valid, 1);
        drain("t1", 50);
        chk("t1_rsp_cnt", rsp_cnt, 1);

        // 2: read returning 0x12345678
        use_rd = 1'b1; force_rd = 32'h1234_5678; force_d = 2;
        feed_q.push_back('{32'h0300_0300, 32'hCAFE_F00D, 4'h0});
        drive();
        drain("t2", 50);
        chk("t2_rsp_cnt", rsp_cnt, 2);
        use_rd = 1'b0;

        // 3: backpressure with 8 commands held on the input
        rsp_pct = 0; force_d = 1; base = accepted;
        for (int i = 0; i < 8; i++) feed_q.push_back('{32'h0300_0000 + 32'(i * 4), $urandom(), 4'(i % 2 == 0 ? 4'h0 : 4'h3)});
        drive();
        repeat (20) cyc();
        chk("t3_accepted", accepted - base, 5);
        chk("t3_cmd_ready", cmd_ready, 0);
        chk("t3_rsp_waiting", rsp_valid, 1);
        rsp_pct = 100;
        drive();
        drain("t3", 200);
        chk("t3_rsp_cnt", rsp_cnt, 10);

        // 4: silent responder times out; a late ready pulse is ignored
        force_d = 20; rsp_pct = 0;
        feed_q.push_back('{32'h0300_0700, 32'h0, 4'h0});
        drive();
        n = 0;
        while (!rsp_valid && n < 30) begin cyc(); n++; end
        chk("t4_rsp_seen", rsp_valid, 1);
        iomem_ready = 1'b1; iomem_rdata = 32'hDEAD_BEEF;
        cyc();
        rsp_pct = 100;
        drive();
        drain("t4", 50);
        repeat (5) cyc();
        chk("t4_no_second_rsp", rsp_valid, 0);
        chk("t4_rsp_cnt", rsp_cnt, 11);

        // 5: ready on the last permitted cycle wins over the timeout
        force_d = T; use_rd = 1'b1; force_rd = 32'hA5A5_0001;
        feed_q.push_back('{32'h0300_0304, 32'h0, 4'h0});
        drive();
        drain("t5", 50);
        chk("t5_rsp_cnt", rsp_cnt, 12);
        use_rd = 1'b0;

        // 6: asynchronous reset mid-request with two commands queued
        force_d = 20;
        for (int i = 0; i < 3; i++) feed_q.push_back('{32'h0300_0900 + 32'(i), 32'(i), 4'h1});
        drive();
        repeat (3) cyc();
        chk("t6_in_req", iomem_valid, 1);
        chk("t6_busy", busy, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_async_valid", iomem_valid, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_cmd_ready", cmd_ready, 0);
        chk("t6_async_rsp_valid", rsp_valid, 0);
        pend.delete(); expq.delete(); feed_q.delete();
        prev_valid = 1'b0; cmd_valid = 1'b0; iomem_ready = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        base = rsp_cnt;
        repeat (5) cyc();
        chk("t6_busy_idle", busy, 0);
        chk("t6_no_rsp", rsp_valid, 0);
        chk("t6_rsp_cnt_same", rsp_cnt, base);
        force_d = 2;
        feed_q.push_back('{32'h0300_0A00, 32'h5555_AAAA, 4'hC});
        drive();
        drain("t6", 50);
        chk("t6_fresh_done", rsp_cnt, base + 1);

        // Random traffic with spurious ready pulses and response backpressure
        force_d = 0; cmd_pct = 70; rsp_pct = 60; spur_pct = 10;
        base = rsp_cnt;
        for (int i = 0; i < 40; i++) begin
            feed_q.push_back('{32'h0300_0000 | ($urandom() & 32'h0000_FFFC), $urandom(),
                               ($urandom_range(2) == 0) ? 4'h0 : 4'($urandom_range(1, 15))});
        end
        drive();
        drain("rand", 3000);
        chk("rand_rsp_cnt", rsp_cnt, base + 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
